// File: rtl/rcc_prog_div_if.sv
// Control/status bundle for rcc_prog_div: ratio/run requests in; divided clock, enable and change status out.
interface rcc_prog_div_if #(
  parameter int RATIO_WID = 9
);
  logic [RATIO_WID-1:0] ratio;
  logic                 clk_en;
  logic                 o_clk;
  logic                 div_en;
  logic                 busy;
  logic                 upd;
  logic [RATIO_WID:0]   cur_ratio;

  modport master (
    output ratio, clk_en,
    input  o_clk, div_en, busy, upd, cur_ratio
  );

  modport slave (
    input  ratio, clk_en,
    output o_clk, div_en, busy, upd, cur_ratio
  );
endinterface

// File: rtl/rcc_prog_div.sv
// Glitch-free runtime-programmable clock divider (1..2^RATIO_WID); ratio lags input by one cycle, changes and
// run/stop land only at period boundaries. Optional RCC_DIV_ODD50_EN gives 50% duty on odd ratios.
module rcc_prog_div #(
  parameter int RATIO_WID = 9,
  parameter int RST_RATIO = 1
) (
  input logic           i_clk,
  input logic           rst,
  rcc_prog_div_if.slave bus
);
  localparam logic [RATIO_WID-1:0] RST_CODE = RATIO_WID'(RST_RATIO);
  localparam logic [RATIO_WID:0]   ONE      = {{RATIO_WID{1'b0}}, 1'b1};

  // Code 0 stands for the largest ratio, 2^RATIO_WID.
  function automatic logic [RATIO_WID:0] decode(input logic [RATIO_WID-1:0] code);
    logic [RATIO_WID:0] r;
    r = {1'b0, code};
    if (code == '0) r[RATIO_WID] = 1'b1;
    return r;
  endfunction

  logic [RATIO_WID-1:0] ratio_f_q;
  logic [RATIO_WID-1:0] ratio_act_q, ratio_act_d;
  logic [RATIO_WID:0]   cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 upd_q, upd_d;
  logic                 div_q, div_d;
  logic                 sel_byp_q;
  logic [RATIO_WID:0]   r_cur, r_last, r_nxt;
  logic                 r_is1, bnd, byp_want, div_out;

  assign r_cur  = decode(ratio_act_q);
  assign r_last = r_cur - ONE;
  assign r_is1  = (r_cur == ONE);
  assign bnd    = !run_q || r_is1 || (cnt_q == r_last);

  always_comb begin
    ratio_act_d = ratio_act_q;
    cnt_d       = cnt_q + ONE;
    run_d       = run_q;
    upd_d       = 1'b0;
    if (bnd) begin
      ratio_act_d = ratio_f_q;
      cnt_d       = '0;
      run_d       = bus.clk_en;
      upd_d       = (ratio_f_q != ratio_act_q);
    end
    r_nxt = decode(ratio_act_d);
    // Phase is held low until the bypass mux has released, so leaving bypass never merges pulses.
    div_d = run_d && (r_nxt != ONE) && !sel_byp_q && (cnt_d < (r_nxt >> 1));
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      ratio_f_q   <= RST_CODE;
      ratio_act_q <= RST_CODE;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      upd_q       <= 1'b0;
      div_q       <= 1'b0;
    end else begin
      ratio_f_q   <= bus.ratio;
      ratio_act_q <= ratio_act_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      upd_q       <= upd_d;
      div_q       <= div_d;
    end
  end

  // Mux select moves only while both mux inputs are low (falling i_clk, div_q low).
  assign byp_want = run_q && r_is1;

  always_ff @(negedge i_clk or posedge rst) begin
    if (rst)         sel_byp_q <= 1'b0;
    else if (!div_q) sel_byp_q <= byp_want;
  end

`ifdef RCC_DIV_ODD50_EN
  logic div_qn_q;

  always_ff @(negedge i_clk or posedge rst) begin
    if (rst) div_qn_q <= 1'b0;
    else     div_qn_q <= div_q;
  end

  assign div_out = div_q | (ratio_act_q[0] & !r_is1 & div_qn_q);
`else
  assign div_out = div_q;
`endif

  assign bus.o_clk     = sel_byp_q ? i_clk : div_out;
  assign bus.div_en    = run_q & (r_is1 | (cnt_q == r_last));
  assign bus.busy      = (ratio_f_q != ratio_act_q);
  assign bus.upd       = upd_q;
  assign bus.cur_ratio = r_cur;
endmodule

// File: tb/tb_rcc_prog_div.sv
// Randomized self-checking bench for rcc_prog_div against a period-level reference model.
module tb_rcc_prog_div;
  localparam int RW   = 9;
  localparam int RSTR = 1;
`ifdef RCC_DIV_ODD50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic rst   = 1'b0;

  rcc_prog_div_if #(.RATIO_WID(RW)) bus ();

  rcc_prog_div #(.RATIO_WID(RW), .RST_RATIO(RSTR)) dut (
    .i_clk (i_clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: requested code (one-cycle lag), active code, position in period, run flag.
  int m_req, m_act, m_pos, settle;
  bit m_run, m_upd;

  bit  mon_en = 1'b0;
  real last_t = 0.0;
  real min_w  = 1.0e9;
  int  n_upd  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec(input int code);
    return (code == 0) ? (1 << RW) : code;
  endfunction

  function automatic void model_reset();
    m_req  = RSTR;
    m_act  = RSTR;
    m_pos  = 0;
    m_run  = 1'b0;
    m_upd  = 1'b0;
    settle = 3;
  endfunction

  function automatic void model_step();
    int r_old, old_act;
    bit old_run, at_end;
    r_old   = dec(m_act);
    old_act = m_act;
    old_run = m_run;
    at_end  = !m_run || (r_old == 1) || (m_pos == r_old - 1);
    if (settle > 0) settle--;
    m_upd = 1'b0;
    if (at_end) begin
      m_upd = (m_req != m_act);
      m_act = m_req;
      m_pos = 0;
      m_run = bus.clk_en;
      // Entering or leaving bypass: the mux hand-off shortens the first period.
      if ((r_old == 1 || dec(m_act) == 1) && (m_act != old_act || m_run != old_run))
        settle = dec(m_act) + 2;
    end else begin
      m_pos++;
    end
    m_req = int'(bus.ratio);
  endfunction

  function automatic bit exp_first_half();
    int r, h;
    r = dec(m_act);
    h = r / 2;
    if (!m_run) return 1'b0;
    if (r == 1) return 1'b1;
    return (m_pos < h) || (ODD50 && (r % 2 == 1) && (m_pos == h));
  endfunction

  function automatic bit exp_second_half();
    int r;
    r = dec(m_act);
    if (!m_run || r == 1) return 1'b0;
    return m_pos < r / 2;
  endfunction

  task automatic check_outs();
    int r;
    r = dec(m_act);
    chk("cur_ratio", bus.cur_ratio, r);
    chk("busy", bus.busy, (m_req != m_act));
    chk("upd", bus.upd, m_upd);
    chk("div_en", bus.div_en, m_run && (r == 1 || m_pos == r - 1));
    if (settle == 0) chk("o_clk_hi_half", bus.o_clk, exp_first_half());
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_step();
    #1;
    check_outs();
    @(negedge i_clk);
    #1;
    if (settle == 0) chk("o_clk_lo_half", bus.o_clk, exp_second_half());
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(posedge bus.o_clk or negedge bus.o_clk) begin
    if (mon_en) begin
      if (last_t > 0.0 && ($realtime - last_t) < min_w) min_w = $realtime - last_t;
      last_t = $realtime;
    end
  end

  initial begin
    bus.ratio  = 9'(RSTR);
    bus.clk_en = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_o_clk", bus.o_clk, 0);
    chk("rst_div_en", bus.div_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_upd", bus.upd, 0);
    chk("rst_cur_ratio", bus.cur_ratio, dec(RSTR));
    @(negedge i_clk);
    @(negedge i_clk);
    #1 rst = 1'b0;
    model_reset();

    // Bypass after start-up
    run_cycles(3);
    bus.clk_en = 1'b1;
    run_cycles(12);

    // Divide by 4
    bus.ratio = 9'd4;
    run_cycles(20);

    // Largest ratio, then a change requested mid-period
    bus.ratio = 9'd0;
    run_cycles(300);
    bus.ratio = 9'd2;
    run_cycles(800);

    // Odd ratio
    bus.ratio = 9'd3;
    run_cycles(15);

    // 8 -> 1 -> 8 with pulse-width monitor
    bus.ratio = 9'd8;
    run_cycles(20);
    mon_en = 1'b1;
    n_upd  = 0;
    bus.ratio = 9'd1;
    for (int i = 0; i < 12; i++) begin cycle(); if (bus.upd) n_upd++; end
    bus.ratio = 9'd8;
    for (int i = 0; i < 24; i++) begin cycle(); if (bus.upd) n_upd++; end
    mon_en = 1'b0;
    chk("upd_count_8_1_8", n_upd, 2);
    chk("min_pulse_ge_half", (min_w >= 5.0), 1);

    // Random ratio and run/stop traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        bus.ratio = ($urandom_range(0, 19) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) bus.clk_en = ~bus.clk_en;
      cycle();
    end

    // Stop mid-period at R=16, restart, then reset during the restart
    bus.ratio  = 9'd16;
    bus.clk_en = 1'b1;
    run_cycles(600);
    while (m_pos != 5) cycle();
    bus.clk_en = 1'b0;
    run_cycles(40);
    bus.clk_en = 1'b1;
    @(posedge i_clk);
    model_step();
    #1;
    check_outs();
    chk("restart_o_clk_high", bus.o_clk, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_o_clk", bus.o_clk, 0);
    chk("async_rst_div_en", bus.div_en, 0);
    chk("async_rst_cur_ratio", bus.cur_ratio, dec(RSTR));
    chk("async_rst_busy", bus.busy, 0);
    model_reset();
    @(negedge i_clk);
    #1 rst = 1'b0;
    run_cycles(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
